// File: rtl/mul_accum.sv
// mul_accum: accumulates a stream of unsigned products into a wide sum.
// A beat flagged with in_last closes the dot-product. The result (sum,
// term count, overflow) is then held on an output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. A source holds its payload stable
// while valid is high and ready is low. ready and valid are decoded from
// the state register only, so neither depends combinationally on the
// other side.
module mul_accum #(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 24,
    parameter int CNTWIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*DATAWIDTH-1:0] prod_in,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   clr,
    output logic [ACCWIDTH-1:0]    sum_out,
    output logic [CNTWIDTH-1:0]    cnt_out,
    output logic                   ovf_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int PW = 2 * DATAWIDTH;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // state_q is kept as a plain named register so checkers can bind to it
    state_t                state_q;
    logic [ACCWIDTH-1:0]   acc;
    logic [CNTWIDTH-1:0]   cnt;
    logic                  ovf;

    logic                  accept;
    logic [ACCWIDTH:0]     acc_sum;
    logic [CNTWIDTH-1:0]   cnt_next;
    logic                  ovf_next;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid & in_ready;

    // Next-value arithmetic. The extra top bit of acc_sum is the carry out.
    always_comb begin
        acc_sum  = {1'b0, acc} + {{(ACCWIDTH + 1 - PW){1'b0}}, prod_in};
        cnt_next = (cnt == {CNTWIDTH{1'b1}}) ? cnt : cnt + 1'b1;
        ovf_next = ovf | acc_sum[ACCWIDTH];
    end

    // Control FSM plus the accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_out <= '0;
            cnt_out <= '0;
            ovf_out <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (clr) begin
                        // clr beats a coincident accept: the beat is consumed and dropped
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (accept) begin
                        if (in_last) begin
                            sum_out <= acc_sum[ACCWIDTH-1:0];
                            cnt_out <= cnt_next;
                            ovf_out <= ovf_next;
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            state_q <= ST_HOLD;
                        end else begin
                            acc <= acc_sum[ACCWIDTH-1:0];
                            cnt <= cnt_next;
                            ovf <= ovf_next;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accum.sv
// Bench for mul_accum: directed product streams, an expected-result queue
// filled by the stimulus, and an independent monitor that compares the
// presented result on every cycle out_valid is high.
module tb_mul_accum;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int CW = 8;
    localparam int EW = AW + CW + 1;

    logic          clk;
    logic          rst_n;
    logic [2*DW-1:0] prod_in;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          clr;
    logic [AW-1:0] sum_out;
    logic [CW-1:0] cnt_out;
    logic          ovf_out;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    // Expected results packed as {sum, cnt, ovf}
    logic [EW-1:0] exp_q[$];

    mul_accum #(.DATAWIDTH(DW), .ACCWIDTH(AW), .CNTWIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .clr       (clr),
        .sum_out   (sum_out),
        .cnt_out   (cnt_out),
        .ovf_out   (ovf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] s, input logic [CW-1:0] c, input logic o);
        exp_q.push_back({s, c, o});
    endtask

    // Present one beat at the negedge and return right after the edge that accepts it
    task automatic send(input logic [2*DW-1:0] p, input logic last, input logic c);
        int waits;
        waits = 0;
        @(negedge clk);
        prod_in  = p;
        in_last  = last;
        in_valid = 1'b1;
        clr      = c;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waits);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: sum %0d cnt %0d ovf %0d with nothing expected",
                             sum_out, cnt_out, ovf_out);
                end else begin
                    e = exp_q[0];
                    check("sum_out", 32'(sum_out), 32'(e[EW-1:CW+1]));
                    check("cnt_out", 32'(cnt_out), 32'(e[CW:1]));
                    check("ovf_out", 32'(ovf_out), 32'(e[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waits;
        rst_n     = 1'b0;
        prod_in   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum_out), 0);
        check("rst_cnt", 32'(cnt_out), 0);
        check("rst_ovf", 32'(ovf_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum: 14+125+65+39 = 243
        push_exp(24'd243, 8'd4, 1'b0);
        send(16'd14, 1'b0, 1'b0);
        send(16'd125, 1'b0, 1'b0);
        send(16'd65, 1'b0, 1'b0);
        send(16'd39, 1'b1, 1'b0);
        idle();
        check("basic_out_valid_rise", 32'(out_valid), 1);
        check("basic_in_ready_hold", 32'(in_ready), 0);
        @(negedge clk);
        check("basic_out_valid_one_cycle", 32'(out_valid), 0);
        check("basic_in_ready_back", 32'(in_ready), 1);

        // Backpressure: 243 held for 5 cycles while a beat of 9 waits upstream
        out_ready = 1'b0;
        push_exp(24'd243, 8'd4, 1'b0);
        push_exp(24'd9, 8'd1, 1'b0);
        send(16'd14, 1'b0, 1'b0);
        send(16'd125, 1'b0, 1'b0);
        send(16'd65, 1'b0, 1'b0);
        send(16'd39, 1'b1, 1'b0);
        @(negedge clk);
        prod_in  = 16'd9;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", 32'(in_ready), 0);
            check("bp_out_valid_high", 32'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_in_ready", 32'(in_ready), 1);
        check("bp_resume_out_valid", 32'(out_valid), 0);
        idle();
        check("bp_second_result", 32'(out_valid), 1);
        @(negedge clk);

        // Overflow and count saturation: 259 * 65025 mod 2^24 = 64259
        push_exp(24'd64259, 8'd255, 1'b1);
        for (int i = 0; i < 258; i++) send(16'd65025, 1'b0, 1'b0);
        send(16'd65025, 1'b1, 1'b0);
        idle();
        push_exp(24'd1, 8'd1, 1'b0);
        send(16'd1, 1'b1, 1'b0);
        idle();

        // Clear colliding with a last beat: no result, then a fresh dot-product
        send(16'd100, 1'b0, 1'b0);
        send(16'd200, 1'b0, 1'b0);
        send(16'd50, 1'b1, 1'b1);
        idle();
        check("clr_no_out_valid", 32'(out_valid), 0);
        check("clr_in_ready", 32'(in_ready), 1);
        push_exp(24'd7, 8'd1, 1'b0);
        send(16'd7, 1'b1, 1'b0);
        idle();
        @(negedge clk);

        // Reset mid-accumulation, pulsed between edges
        send(16'd1000, 1'b0, 1'b0);
        send(16'd1000, 1'b0, 1'b0);
        send(16'd1000, 1'b0, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum_out), 0);
        check("mid_rst_cnt", 32'(cnt_out), 0);
        check("mid_rst_ovf", 32'(ovf_out), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        #1;
        rst_n = 1'b1;
        push_exp(24'd5, 8'd1, 1'b0);
        send(16'd5, 1'b1, 1'b0);
        idle();

        // Single-beat dot-product of the largest product
        push_exp(24'd65535, 8'd1, 1'b0);
        send(16'hFFFF, 1'b1, 1'b0);
        idle();

        // Drain: every expected result must have been presented
        waits = 0;
        while (exp_q.size() != 0 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("drain_pending_results", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_accum.md
# mul_accum

Downstream accumulation stage for the combinational `MUL` multiplier. It consumes a stream of `2*DATAWIDTH`-bit products over a valid/ready handshake and sums them into a wide accumulator. It closes a dot-product on a `last`-flagged beat and presents the sum, term count and overflow flag on an output handshake. The block sits between `MUL` (product source) and whatever consumes dot-product results.

## Interface
- `DATAWIDTH`, 8, operand width of the upstream `MUL`; the product is `2*DATAWIDTH` bits.
- `ACCWIDTH`, 24, accumulator and result width; must be ≥ `2*DATAWIDTH`.
- `CNTWIDTH`, 8, term-counter width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `prod_in`  in  2*DATAWIDTH  unsigned product from `MUL`.
- `in_valid`  in  1  `prod_in` and `in_last` are valid.
- `in_last`  in  1  this beat is the final term of the current dot-product.
- `in_ready`  out  1  block can accept a beat.
- `clr`  in  1  synchronous discard of the partial accumulation.
- `sum_out`  out  ACCWIDTH  completed dot-product sum.
- `cnt_out`  out  CNTWIDTH  number of terms in `sum_out`, saturating.
- `ovf_out`  out  1  sticky: the accumulation wrapped past `2^ACCWIDTH-1`.
- `out_valid`  out  1  `sum_out`, `cnt_out` and `ovf_out` are valid.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Two states:
  - ACC: accepting beats. `in_ready`=1, `out_valid`=0.
  - HOLD: result presented. `in_ready`=0, `out_valid`=1.
- Accept = `in_valid & in_ready`.
- On accept in ACC:
  - Accumulation: `acc <= acc + zero_ext(prod_in)`, modulo `2^ACCWIDTH`.
  - Overflow: a carry out of bit `ACCWIDTH-1` sets internal `ovf`, which stays set until the dot-product closes.
  - Counting: `cnt <= cnt+1`, saturating at `2^CNTWIDTH-1`. Count saturation does not set `ovf`.
- Accept with `in_last`=1:
  - Latches `sum_out <= acc+prod`, the updated `cnt` into `cnt_out`, and the updated `ovf` (including a carry from this beat) into `ovf_out`.
  - Clears `acc`, `cnt` and `ovf` to 0.
  - Moves to HOLD.
- In HOLD:
  - Outputs are stable until `out_valid & out_ready`.
  - On that handshake the block returns to ACC on the next edge.
- `clr` in ACC clears `acc`, `cnt` and `ovf` at the next edge.
  - If `clr` coincides with an accept, `clr` wins. The beat is consumed (handshake completes) but discarded, and an `in_last` on it produces no result.
- `clr` in HOLD is ignored. The pending result is not affected.
- Outputs are registered. `in_ready` and `out_valid` are decoded directly from the state register.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - state ACC
  - `acc`, `cnt`, `ovf` = 0
  - `sum_out` = 0, `cnt_out` = 0, `ovf_out` = 0
  - `out_valid` = 0, `in_ready` = 1 (driven immediately, no clock needed)
- Reset mid-accumulation or during HOLD drops all partial or pending results.
- Throughput in ACC is one beat per cycle, with no bubbles between beats.
- Latency: the `in_last` accept at edge N gives `out_valid`=1 after edge N.
- Turnaround: the output handshake at edge M gives `in_ready`=1 after edge M. This is one dead cycle per dot-product, and in/out never overlap.
- `out_ready` high while in ACC has no effect.
- `in_valid` high while in HOLD is not accepted. Upstream holds its beat.

## Test plan
- Basic sum:
  - Stimulus: products 14, 125, 65, 39 (7×2, 25×5, 5×13, 39×1) on consecutive cycles, `in_last` on the 4th, `out_ready`=1.
  - Required: `sum_out`=243, `cnt_out`=4, `ovf_out`=0. `out_valid` high for exactly one cycle, one cycle after the last accept. `in_ready`=0 during that cycle.
- Backpressure:
  - Stimulus: the same stream with `out_ready`=0 for 5 cycles after `out_valid` rises, and `in_valid`=1 throughout.
  - Required: `sum_out`=243 held stable, `in_ready`=0 for all 5 cycles, no beat consumed. Accepts resume in the cycle after the handshake.
- Overflow and count saturation:
  - Stimulus 1: 259 beats of 65025 (255×255), last on the 259th.
  - Required 1: `sum_out`=64259 (16841475 mod 2^24), `ovf_out`=1, `cnt_out`=255.
  - Stimulus 2: a following single-beat dot-product of 1.
  - Required 2: `sum_out`=1, `cnt_out`=1, `ovf_out`=0.
- Clear collision:
  - Stimulus 1: beats 100 and 200, then a beat of 50 with `in_last`=1 and `clr`=1 in the same cycle.
  - Required 1: no `out_valid`.
  - Stimulus 2: a next beat of 7 with `in_last`.
  - Required 2: `sum_out`=7, `cnt_out`=1.
- Reset mid-operation:
  - Stimulus 1: 3 beats of 1000, then `rst_n` pulsed low between edges.
  - Required 1: all outputs 0 and `in_ready`=1 immediately.
  - Stimulus 2: a following single-beat dot-product of 5.
  - Required 2: `sum_out`=5, `cnt_out`=1.
- Single-beat dot-product:
  - Stimulus: `prod_in`=0xFFFF with `in_last`=1.
  - Required: `sum_out`=65535, `cnt_out`=1, `ovf_out`=0.
